// File: rtl/hazard_tag_pipe.sv
// Carries register tags, RegWrite and Tnew from D through E/M/W for the hazard unit; E takes a bubble on stall.
// One cycle per stage; stall gates PC and F/D combinationally; M and W are never stalled.
module hazard_tag_pipe #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D_valid,
  input  logic [REG_AW-1:0] D_A1,
  input  logic [REG_AW-1:0] D_A2,
  input  logic [REG_AW-1:0] D_A3,
  input  logic              D_RegWrite,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              stall,
  input  logic              stall_cnt_clr,
  output logic              pc_en,
  output logic              fd_en,
  output logic              de_clr,
  output logic              E_valid,
  output logic              M_valid,
  output logic              W_valid,
  output logic [REG_AW-1:0] E_A1,
  output logic [REG_AW-1:0] E_A2,
  output logic [REG_AW-1:0] E_A3,
  output logic              E_RegWrite,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [REG_AW-1:0] M_A2,
  output logic [REG_AW-1:0] M_A3,
  output logic              M_RegWrite,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic [REG_AW-1:0] W_A3,
  output logic              W_RegWrite,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
    logic [REG_AW-1:0] a3;
    logic              rw;
    logic [TNEW_W-1:0] tnew;
  } e_stage_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] a2;
    logic [REG_AW-1:0] a3;
    logic              rw;
    logic [TNEW_W-1:0] tnew;
  } m_stage_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] a3;
    logic              rw;
  } w_stage_t;

  localparam logic [TNEW_W-1:0] TNEW_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  e_stage_t e_q, e_nxt;
  m_stage_t m_q, m_nxt;
  w_stage_t w_q, w_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_clr = stall;

  // A stalled cycle loads an all-zero bubble so no stale tag can match downstream.
  always_comb begin
    e_nxt = '0;
    if (!stall) begin
      e_nxt.valid = D_valid;
      e_nxt.a1    = D_A1;
      e_nxt.a2    = D_A2;
      e_nxt.a3    = D_A3;
      e_nxt.rw    = D_RegWrite & D_valid & (D_A3 != '0);
      e_nxt.tnew  = D_Tnew;
    end
  end

  always_comb begin
    m_nxt       = '0;
    m_nxt.valid = e_q.valid;
    m_nxt.a2    = e_q.a2;
    m_nxt.a3    = e_q.a3;
    m_nxt.rw    = e_q.rw;
    m_nxt.tnew  = (e_q.tnew == '0) ? '0 : e_q.tnew - TNEW_ONE;
  end

  always_comb begin
    w_nxt       = '0;
    w_nxt.valid = m_q.valid;
    w_nxt.a3    = m_q.a3;
    w_nxt.rw    = m_q.rw;
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (stall_cnt_clr) begin
      cnt_nxt = '0;
    end else if (stall && D_valid && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_nxt;
      m_q   <= m_nxt;
      w_q   <= w_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign E_valid    = e_q.valid;
  assign E_A1       = e_q.a1;
  assign E_A2       = e_q.a2;
  assign E_A3       = e_q.a3;
  assign E_RegWrite = e_q.rw;
  assign E_Tnew     = e_q.tnew;
  assign M_valid    = m_q.valid;
  assign M_A2       = m_q.a2;
  assign M_A3       = m_q.a3;
  assign M_RegWrite = m_q.rw;
  assign M_Tnew     = m_q.tnew;
  assign W_valid    = w_q.valid;
  assign W_A3       = w_q.a3;
  assign W_RegWrite = w_q.rw;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: table-driven pipeline stream plus reset, counter and clear sequences.
module tb_hazard_tag_pipe;

  localparam int REG_AW = 5;
  localparam int TNEW_W = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              D_valid;
  logic [REG_AW-1:0] D_A1, D_A2, D_A3;
  logic              D_RegWrite;
  logic [TNEW_W-1:0] D_Tnew;
  logic              stall;
  logic              stall_cnt_clr;
  logic              pc_en, fd_en, de_clr;
  logic              E_valid, M_valid, W_valid;
  logic [REG_AW-1:0] E_A1, E_A2, E_A3;
  logic              E_RegWrite;
  logic [TNEW_W-1:0] E_Tnew;
  logic [REG_AW-1:0] M_A2, M_A3;
  logic              M_RegWrite;
  logic [TNEW_W-1:0] M_Tnew;
  logic [REG_AW-1:0] W_A3;
  logic              W_RegWrite;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_tag_pipe #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_valid(D_valid), .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3),
    .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew),
    .stall(stall), .stall_cnt_clr(stall_cnt_clr),
    .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
    .E_valid(E_valid), .M_valid(M_valid), .W_valid(W_valid),
    .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_RegWrite(E_RegWrite), .E_Tnew(E_Tnew),
    .M_A2(M_A2), .M_A3(M_A3), .M_RegWrite(M_RegWrite), .M_Tnew(M_Tnew),
    .W_A3(W_A3), .W_RegWrite(W_RegWrite),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d_v, d_a1, d_a2, d_a3, d_rw, d_t, st;
    int e_v, e_a1, e_a2, e_a3, e_rw, e_t;
    int m_v, m_a2, m_a3, m_rw, m_t;
    int w_v, w_a3, w_rw;
    int cnt;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(input int dv, a1, a2, a3, rw, t, st,
                              input int ev, ea1, ea2, ea3, erw, et,
                              input int mv, ma2, ma3, mrw, mt,
                              input int wv, wa3, wrw, cnt);
    vec_t r;
    r.d_v = dv; r.d_a1 = a1; r.d_a2 = a2; r.d_a3 = a3; r.d_rw = rw; r.d_t = t; r.st = st;
    r.e_v = ev; r.e_a1 = ea1; r.e_a2 = ea2; r.e_a3 = ea3; r.e_rw = erw; r.e_t = et;
    r.m_v = mv; r.m_a2 = ma2; r.m_a3 = ma3; r.m_rw = mrw; r.m_t = mt;
    r.w_v = wv; r.w_a3 = wa3; r.w_rw = wrw; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int dv, a1, a2, a3, rw, t, st);
    D_valid    = dv[0];
    D_A1       = REG_AW'(a1);
    D_A2       = REG_AW'(a2);
    D_A3       = REG_AW'(a3);
    D_RegWrite = rw[0];
    D_Tnew     = TNEW_W'(t);
    stall      = st[0];
  endtask

  function automatic int e_pack();
    return int'({E_valid, E_A1, E_A2, E_A3, E_RegWrite, E_Tnew});
  endfunction
  function automatic int m_pack();
    return int'({M_valid, M_A2, M_A3, M_RegWrite, M_Tnew});
  endfunction
  function automatic int w_pack();
    return int'({W_valid, W_A3, W_RegWrite});
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_e"}, e_pack(), 0);
    chk({name, "_m"}, m_pack(), 0);
    chk({name, "_w"}, w_pack(), 0);
    chk({name, "_cnt"}, int'(stall_cnt), 0);
  endtask

  initial begin
    // D: valid a1 a2 a3 rw t st | E: v a1 a2 a3 rw t | M: v a2 a3 rw t | W: v a3 rw | cnt
    tbl[0] = mk(1, 3, 4, 5, 1, 2, 0,   1, 3, 4, 5, 1, 2,   0, 0, 0, 0, 0,     0, 0, 0,    0);
    tbl[1] = mk(1, 1, 2, 7, 1, 1, 1,   0, 0, 0, 0, 0, 0,   1, 4, 5, 1, 1,     0, 0, 0,    1);
    tbl[2] = mk(1, 1, 2, 7, 1, 1, 0,   1, 1, 2, 7, 1, 1,   0, 0, 0, 0, 0,     1, 5, 1,    1);
    tbl[3] = mk(1, 6, 0, 0, 1, 2, 0,   1, 6, 0, 0, 0, 2,   1, 2, 7, 1, 0,     0, 0, 0,    1);
    tbl[4] = mk(1, 8, 9, 10, 1, 0, 0,  1, 8, 9, 10, 1, 0,  1, 0, 0, 0, 1,     1, 7, 1,    1);
    tbl[5] = mk(1, 11, 12, 13, 0, 1, 0, 1, 11, 12, 13, 0, 1, 1, 9, 10, 1, 0,  1, 0, 0,    1);
    tbl[6] = mk(0, 14, 15, 16, 1, 3, 0, 0, 14, 15, 16, 0, 3, 1, 12, 13, 0, 0, 1, 10, 1,   1);
    tbl[7] = mk(1, 1, 1, 1, 1, 0, 0,   1, 1, 1, 1, 1, 0,   0, 15, 16, 0, 2,   1, 13, 0,   1);
    tbl[8] = mk(0, 0, 0, 2, 1, 1, 1,   0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0,     0, 16, 0,   1);

    rst_n = 1'b0;
    stall_cnt_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      @(negedge clk);
      drive(v.d_v, v.d_a1, v.d_a2, v.d_a3, v.d_rw, v.d_t, v.st);
      #1;
      chk($sformatf("row%0d_ctl", i), int'({pc_en, fd_en, de_clr}),
          (v.st != 0) ? 1 : 6);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_e", i), e_pack(),
          int'({v.e_v[0], REG_AW'(v.e_a1), REG_AW'(v.e_a2), REG_AW'(v.e_a3), v.e_rw[0], TNEW_W'(v.e_t)}));
      chk($sformatf("row%0d_m", i), m_pack(),
          int'({v.m_v[0], REG_AW'(v.m_a2), REG_AW'(v.m_a3), v.m_rw[0], TNEW_W'(v.m_t)}));
      chk($sformatf("row%0d_w", i), w_pack(),
          int'({v.w_v[0], REG_AW'(v.w_a3), v.w_rw[0]}));
      chk($sformatf("row%0d_cnt", i), int'(stall_cnt), v.cnt);
    end

    // Fill E/M/W, then assert reset mid-cycle and check it acts before the next edge.
    @(negedge clk);
    drive(1, 2, 3, 4, 1, 2, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1, 2, 3, 1, 1, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    chk("reset_ctl_driven", int'({pc_en, fd_en, de_clr}), 1);
    @(posedge clk);
    #1;
    chk("reset_held_e", e_pack(), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("release_pc_en", int'(pc_en), 1);

    // 20 back-to-back stalls with a held D instruction: counter saturates at 15.
    begin
      int exp_cnt;
      exp_cnt = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        drive(1, 9, 10, 11, 1, 2, 1);
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
        chk($sformatf("sat_cnt%0d", k), int'(stall_cnt), exp_cnt);
      end
      chk("stall_run_e_bubble", e_pack(), 0);
      chk("stall_run_m_bubble", m_pack(), 0);
    end

    @(negedge clk);
    drive(1, 9, 10, 11, 1, 2, 0);
    @(posedge clk);
    #1;
    chk("after_stall_e", e_pack(), int'({1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 2'd2}));
    chk("after_stall_cnt_hold", int'(stall_cnt), 15);

    // Clear wins over a simultaneous counting stall.
    @(negedge clk);
    drive(1, 9, 10, 11, 1, 2, 1);
    stall_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_with_stall", int'(stall_cnt), 0);
    @(negedge clk);
    stall_cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("count_after_clr", int'(stall_cnt), 1);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("idle_hold_cnt", int'(stall_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
